// File: rtl/timer_scheduler.sv
// Delay-command scheduler: queues short/long delay commands and issues them one at a
// time to an external down-counter timer, pulsing done when each delay expires.
module timer_scheduler #(
  parameter int DEPTH = 4,
  parameter int GUARD = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs,
  input  logic [3:0]             op,
  input  logic [7:0]             addr,
  input  logic [15:0]            data_in,
  output logic                   tmr_cs,
  output logic [3:0]             tmr_op,
  output logic [7:0]             tmr_addr,
  output logic [15:0]            tmr_data,
  input  logic                   tmr_rdy,
  output logic                   rdy,
  output logic                   done,
  output logic                   busy,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GUARD = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  logic [24:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          ovf_r;
  state_t        state_r;
  state_t        state_s;
  logic [GW-1:0] guard_cnt_r;
  logic [3:0]    tmr_op_r;
  logic [7:0]    tmr_addr_r;
  logic [15:0]   tmr_data_r;

  logic          delay_cmd_s;
  logic          flush_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic          done_s;
  logic [24:0]   head_s;

  // Command decode; nothing is accepted while reset is asserted.
  always_comb begin
    delay_cmd_s = 1'b0;
    flush_s     = 1'b0;
    if (cs && !rst) begin
      case (op[1:0])
        2'b00, 2'b01: delay_cmd_s = 1'b1;
        2'b10:        flush_s     = 1'b1;
        default: begin
          delay_cmd_s = 1'b0;
          flush_s     = 1'b0;
        end
      endcase
    end else begin
      delay_cmd_s = 1'b0;
      flush_s     = 1'b0;
    end
  end

  // Queue handshake: a pop in the same cycle frees a slot for a push even when full.
  always_comb begin
    full_s = (count_r == DEPTH_C);
    pop_s  = (state_r == ST_IDLE) && (count_r != {CW{1'b0}}) && !flush_s && !rst;
    push_s = delay_cmd_s && (!full_s || pop_s);
    drop_s = delay_cmd_s && !push_s;
    done_s = (state_r == ST_RUN) && tmr_rdy && !flush_s && !rst;
    head_s = mem_r[rd_ptr_r];
  end

  // Next-state logic; a flush abandons whatever is running.
  always_comb begin
    state_s = state_r;
    if (flush_s) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_s = pop_s ? ST_ISSUE : ST_IDLE;
        ST_ISSUE: state_s = ST_GUARD;
        ST_GUARD: state_s = (guard_cnt_r == {GW{1'b0}}) ? ST_RUN : ST_GUARD;
        ST_RUN:   state_s = tmr_rdy ? ST_IDLE : ST_RUN;
        default:  state_s = ST_IDLE;
      endcase
    end
  end

  // State register and guard counter that masks stale tmr_rdy after a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      guard_cnt_r <= {GW{1'b0}};
    end else begin
      state_r <= state_s;
      if (state_r == ST_ISSUE) begin
        guard_cnt_r <= GUARD_LOAD;
      end else if ((state_r == ST_GUARD) && (guard_cnt_r != {GW{1'b0}})) begin
        guard_cnt_r <= guard_cnt_r - GW'(1);
      end else begin
        guard_cnt_r <= guard_cnt_r;
      end
    end
  end

  // FIFO storage; entry layout is {long, data_in, addr}.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {op[0], data_in, addr};
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst || flush_s) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Timer operand registers load on pop and hold the last issued values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_op_r   <= 4'h0;
      tmr_addr_r <= 8'h00;
      tmr_data_r <= 16'h0000;
    end else if (pop_s) begin
      tmr_op_r   <= {3'b000, head_s[24]};
      tmr_addr_r <= head_s[7:0];
      tmr_data_r <= head_s[23:8];
    end
  end

  assign tmr_cs   = (state_r == ST_ISSUE);
  assign tmr_op   = tmr_op_r;
  assign tmr_addr = tmr_addr_r;
  assign tmr_data = tmr_data_r;
  assign busy     = (state_r != ST_IDLE);
  assign rdy      = (state_r == ST_IDLE) && (count_r == {CW{1'b0}});
  assign done     = done_s;
  assign full     = full_s;
  assign count    = count_r;
  assign ovf      = ovf_r;

endmodule

// File: tb/tb_timer_scheduler.sv
// Scoreboard bench for timer_scheduler: a queue-based reference model predicts issues,
// completions and status; a negedge monitor compares them against the DUT.
module tb_timer_scheduler;

  localparam int DEPTH = 4;
  localparam int GUARD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic [3:0]  op;
  logic [7:0]  addr;
  logic [15:0] data_in;
  logic        tmr_cs;
  logic [3:0]  tmr_op;
  logic [7:0]  tmr_addr;
  logic [15:0] tmr_data;
  logic        tmr_rdy;
  logic        rdy;
  logic        done;
  logic        busy;
  logic        full;
  logic [2:0]  count;
  logic        ovf;

  timer_scheduler #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .cs(cs), .op(op), .addr(addr), .data_in(data_in),
    .tmr_cs(tmr_cs), .tmr_op(tmr_op), .tmr_addr(tmr_addr), .tmr_data(tmr_data),
    .tmr_rdy(tmr_rdy), .rdy(rdy), .done(done), .busy(busy), .full(full),
    .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Reference model: pending commands, sticky overflow, cycles since the running delay was issued.
  logic [24:0] mq[$];
  bit          m_ovf   = 1'b0;
  int          m_phase = -1;
  logic [24:0] m_last  = '0;

  int          e_count;
  bit          e_full, e_ovf, e_busy, e_rdy;
  logic [24:0] e_last;
  int          done_q[$];
  int          iss_cyc_q[$];
  logic [24:0] iss_val_q[$];

  int tmr_mode = 2;
  int tcnt     = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(bit r, bit c, logic [3:0] o, logic [7:0] a, logic [15:0] d);
    bit          flush, dly, done_now, pop;
    logic [24:0] e;
    rst = r; cs = c; op = o; addr = a; data_in = d;
    // Environment timer: loads on tmr_cs, expires after (addr[4:0] + 2) cycles.
    if (tmr_cs === 1'b1) tcnt = int'(tmr_addr[4:0]) + 2;
    else if (tcnt > 0) tcnt--;
    case (tmr_mode)
      0:       tmr_rdy = ($urandom_range(0, 3) == 0);
      1:       tmr_rdy = 1'b1;
      default: tmr_rdy = (tcnt == 0);
    endcase
    e_count = mq.size();
    e_full  = (mq.size() == DEPTH);
    e_ovf   = m_ovf;
    e_busy  = (m_phase >= 0);
    e_rdy   = (m_phase < 0) && (mq.size() == 0);
    e_last  = m_last;
    if (r) begin
      mq.delete(); m_ovf = 1'b0; m_phase = -1; m_last = '0;
    end else begin
      flush    = c && (o[1:0] == 2'b10);
      dly      = c && !o[1];
      done_now = (m_phase > GUARD) && tmr_rdy && !flush;
      pop      = (m_phase < 0) && (mq.size() > 0) && !flush;
      if (done_now) done_q.push_back(cyc);
      if (flush) begin
        mq.delete(); m_ovf = 1'b0; m_phase = -1;
      end else begin
        if (pop) begin
          e = mq.pop_front();
          m_last = e;
          iss_cyc_q.push_back(cyc + 1);
          iss_val_q.push_back(e);
        end
        if (dly) begin
          if (mq.size() < DEPTH) mq.push_back({o[0], d, a});
          else m_ovf = 1'b1;
        end
        if (done_now) m_phase = -1;
        else if (pop) m_phase = 0;
        else if (m_phase >= 0 && m_phase <= GUARD) m_phase++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 8'h00, 16'h0000);
  endtask

  // Monitor: pops scoreboard entries due this cycle and checks every observable output.
  always @(negedge clk) begin
    bit          exp_done, exp_cs;
    logic [24:0] ev;
    if (mon_en) begin
      exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
      if (exp_done) void'(done_q.pop_front());
      chk("done", 32'(done), 32'(exp_done));
      exp_cs = (iss_cyc_q.size() > 0) && (iss_cyc_q[0] == cyc);
      chk("tmr_cs", 32'(tmr_cs), 32'(exp_cs));
      if (exp_cs) begin
        void'(iss_cyc_q.pop_front());
        ev = iss_val_q.pop_front();
        chk("issue_op",   32'(tmr_op),   32'({3'b000, ev[24]}));
        chk("issue_addr", 32'(tmr_addr), 32'(ev[7:0]));
        chk("issue_data", 32'(tmr_data), 32'(ev[23:8]));
      end
      chk("count",    32'(count),    32'(e_count));
      chk("full",     32'(full),     32'(e_full));
      chk("ovf",      32'(ovf),      32'(e_ovf));
      chk("busy",     32'(busy),     32'(e_busy));
      chk("rdy",      32'(rdy),      32'(e_rdy));
      chk("hold_op",  32'(tmr_op),   32'({3'b000, e_last[24]}));
      chk("hold_addr",32'(tmr_addr), 32'(e_last[7:0]));
      chk("hold_data",32'(tmr_data), 32'(e_last[23:8]));
    end
  end

  initial begin
    bit          r, c;
    logic [3:0]  o;
    rst = 1'b1; cs = 1'b0; op = 4'h0; addr = 8'h00; data_in = 16'h0000; tmr_rdy = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1'b1, 1'b0, 4'h0, 8'h00, 16'h0000);
    step(1'b1, 1'b0, 4'h0, 8'h00, 16'h0000);
    idle(3);

    // Short delay, timer expires 18 cycles after load.
    step(1'b0, 1'b1, 4'h0, 8'h10, 16'h0000);
    idle(28);

    // Long delay whose timer expires during the guard window.
    step(1'b0, 1'b1, 4'h1, 8'h00, 16'h0001);
    idle(12);

    // Fill the queue behind a long-running delay; the fifth push overflows.
    step(1'b0, 1'b1, 4'h1, 8'h1f, 16'hbeef);
    idle(3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'(i & 1), 8'(i + 1), 16'(i * 257));
    idle(120);

    // Timer permanently expired: each delay completes GUARD+1 cycles after its load.
    tmr_mode = 1;
    step(1'b0, 1'b1, 4'h0, 8'h21, 16'h1111);
    step(1'b0, 1'b1, 4'h5, 8'h22, 16'h2222);
    step(1'b0, 1'b1, 4'hc, 8'h23, 16'h3333);
    idle(25);

    // Flush while running with two queued, then an ignored op 11.
    tmr_mode = 2;
    step(1'b0, 1'b1, 4'h1, 8'h1f, 16'haaaa);
    step(1'b0, 1'b1, 4'h0, 8'h02, 16'h0102);
    step(1'b0, 1'b1, 4'h0, 8'h03, 16'h0103);
    idle(5);
    step(1'b0, 1'b1, 4'h2, 8'h00, 16'h0000);
    step(1'b0, 1'b1, 4'h3, 8'h44, 16'h4444);
    idle(40);

    // Reset during the guard window with three queued; cs is ignored under reset.
    step(1'b0, 1'b1, 4'h1, 8'h1e, 16'h5555);
    step(1'b0, 1'b1, 4'h0, 8'h05, 16'h0505);
    step(1'b0, 1'b1, 4'h0, 8'h06, 16'h0606);
    step(1'b0, 1'b1, 4'h1, 8'h07, 16'h0707);
    step(1'b1, 1'b1, 4'h0, 8'h08, 16'h0808);
    idle(10);

    // Randomized traffic with varying timer behaviour.
    for (int blk = 0; blk < 6; blk++) begin
      tmr_mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 100; i++) begin
        c = ($urandom_range(0, 1) == 1);
        o = 4'($urandom);
        if (o[1:0] == 2'b10 && $urandom_range(0, 7) != 0) o[1] = 1'b0;
        r = ($urandom_range(0, 199) == 0);
        step(r, c, o, 8'($urandom), 16'($urandom));
      end
    end
    tmr_mode = 1;
    idle(40);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
